alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one `alu` instance between `N_REQ` requesters. Each requester presents an opcode and two operands through a valid/ready handshake. The block grants one request at a time in round-robin order, sequences the operation into the ALU, and waits the ALU latency. It then returns the captured result to the granted requester over a response handshake.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (>=2).
- `DATA_W`, 4: operand width (matches `alu` OP1/OP2).
- `OPC_W`, 3: opcode width (matches `alu` OPCODE).
- `RES_W`, 5: ALU result width.
- `ALU_LAT`, 1: cycles from `alu_issue` to a valid `alu_res` (>=1).

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req_valid`  in  N_REQ: per-requester request valid.
- `req_ready`  out  N_REQ: per-requester accept strobe; at most one bit set.
- `req_opcode`  in  N_REQ*OPC_W: packed opcodes; requester i occupies bits [i*OPC_W +: OPC_W].
- `req_op1`, `req_op2`  in  N_REQ*DATA_W: packed operands, same packing.
- `alu_opcode`  out  OPC_W: opcode to the ALU.
- `alu_op1`, `alu_op2`  out  DATA_W: operands to the ALU.
- `alu_issue`  out  1: one-cycle strobe marking the cycle in which the ALU inputs are valid.
- `alu_res`  in  RES_W: ALU result, sampled ALU_LAT cycles after `alu_issue`.
- `rsp_valid`  out  N_REQ: one-hot response valid to the granted requester.
- `rsp_data`  out  RES_W: result returned with the response.
- `rsp_ready`  in  N_REQ: per-requester response accept.
- `busy`  out  1: high in every state except IDLE.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Select grant g = first i with `req_valid[i]`, searching from `ptr` upward and wrapping modulo N_REQ.
  - Drive `req_ready[g]`=1 combinationally in the same cycle.
  - On that handshake: latch opcode/op1/op2 of g and g itself, then go to ISSUE.
  - No `req_valid` bit set: stay in IDLE with `req_ready`=0.
- **ISSUE**
  - Drive `alu_opcode`/`alu_op1`/`alu_op2` from the latched values (registered outputs) and `alu_issue`=1 for exactly one cycle.
  - Load the latency counter with ALU_LAT, then go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, capture `alu_res` into the result register and go to RESP.
  - This captures the result exactly ALU_LAT cycles after the `alu_issue` cycle.
- **RESP**
  - `rsp_valid[g]`=1, `rsp_data`=captured result; both held stable until `rsp_ready[g]`=1.
  - On that handshake: set `ptr` = (g+1) mod N_REQ, then go to IDLE.
  - `rsp_ready` bits of non-granted requesters are ignored.

Further rules:
- `alu_opcode`/`alu_op1`/`alu_op2` hold the last issued values outside ISSUE; only `alu_issue` qualifies them.
- Opcodes are passed through unchanged; the block does not decode or check them.
- A requester may drop `req_valid` before it is granted; no grant occurs for it.
- Once granted, later changes on that requester's inputs are ignored.
- `req_ready` is 0 in all states except IDLE.

## Timing
- **Reset** (`rst`=1 at a rising edge):
  - state=IDLE, `ptr`=0, latched operands=0, result=0.
  - `req_ready`=0, `alu_opcode`=0, `alu_op1`=0, `alu_op2`=0, `alu_issue`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
  - `req_ready` remains 0 while `rst`=1, regardless of `req_valid`.
- **Latency**, with acceptance in cycle T:
  - `alu_issue` in T+1.
  - `alu_res` sampled in T+1+ALU_LAT.
  - `rsp_valid` asserted from T+2+ALU_LAT.
- **Throughput**: one operation per at most ALU_LAT+3 cycles when `rsp_ready` is held high.
- **Reset mid-operation** (ISSUE, WAIT or RESP): the operation is aborted and its result discarded. No `rsp_valid` is produced. `ptr` returns to 0 and the requester must re-request.
- **Simultaneous requests**: exactly one is granted per IDLE visit; the others wait with `req_ready`=0.
- **Round-robin wrap-around**: after granting N_REQ-1, `ptr` wraps to 0.
- **Starvation bound**: a continuously valid requester is granted within N_REQ operations.

## Test plan
- **Reset**: `rst`=1 for 2 cycles with `req_valid`=2'b11 -> every output is 0 and `req_ready` stays 0; first grant after release goes to requester 0.
- **Single op**: ALU_LAT=1, req0 with opcode 3'b000, op1 4'h3, op2 4'h5; ALU model returns 5'h08; `rsp_ready` tied high.
  - `req_ready`=2'b01 in T.
  - `alu_issue`=1 in T+1 with 000/3/5.
  - `rsp_valid`=2'b01 with `rsp_data`=5'h08 in T+3.
  - IDLE again in T+4.
- **Fairness**: both requesters hold `req_valid` for 8 operations -> grant order 0,1,0,1,0,1,0,1 and each response goes to the matching requester.
- **Backpressure**: `rsp_ready[0]`=0 for 5 cycles during RESP -> `rsp_valid` and `rsp_data` stay stable, `req_ready[1]` stays 0 although req1 is valid; req1 is granted the cycle after `rsp_ready[0]`=1.
- **Reset mid-WAIT**: ALU_LAT=3, `rst`=1 for 1 cycle during WAIT -> `rsp_valid` is never asserted for that operation and `busy`=0 the next cycle.
- **Wrap-around**: N_REQ=3, only req2 valid -> req2 is granted, then `ptr`=0; with req0 and req2 then both valid, req0 is granted next.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among N_REQ requesters.
// Each operation is granted, issued, timed for ALU_LAT cycles, then returned to its requester.
module alu_arbiter #(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 4,
  parameter int OPC_W   = 3,
  parameter int RES_W   = 5,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OPC_W-1:0]  req_opcode,
  input  logic [N_REQ*DATA_W-1:0] req_op1,
  input  logic [N_REQ*DATA_W-1:0] req_op2,
  output logic [OPC_W-1:0]        alu_opcode,
  output logic [DATA_W-1:0]       alu_op1,
  output logic [DATA_W-1:0]       alu_op2,
  output logic                    alu_issue,
  input  logic [RES_W-1:0]        alu_res,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [RES_W-1:0]        rsp_data,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic                    busy
);

  // state | meaning
  // IDLE  | search from ptr for a valid requester, accept it combinationally
  // ISSUE | present latched operands to the ALU with alu_issue, load latency timer
  // WAIT  | count down; capture alu_res at terminal count 1
  // RESP  | hold rsp_valid/rsp_data for the granted requester until it accepts

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    grant_q, grant_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0]    res_q, res_d;

  logic [PTR_W-1:0]    sel;
  logic                sel_vld;
  int                  idx;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    sel     = ptr_q;
    sel_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!sel_vld && req_valid[idx]) begin
        sel_vld = 1'b1;
        sel     = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    opc_d     = opc_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          req_ready[sel] = 1'b1;
          grant_d        = sel;
          opc_d          = req_opcode[sel*OPC_W +: OPC_W];
          op1_d          = req_op1[sel*DATA_W +: DATA_W];
          op2_d          = req_op2[sel*DATA_W +: DATA_W];
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(ALU_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          res_d   = alu_res;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          ptr_d   = (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing may be accepted while reset is asserted.
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      opc_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      opc_q   <= opc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Latched operands double as the ALU input registers; alu_issue qualifies them.
  assign alu_opcode = opc_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_issue  = (state_q == ISSUE);
  assign rsp_data   = res_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: randomized requesters, behavioural ALU and
// a transaction-level arbitration model feeding expected issue/response queues.
module tb_alu_arbiter;

  localparam int N   = 3;
  localparam int DW  = 4;
  localparam int OW  = 3;
  localparam int RW  = 5;
  localparam int LAT = 3;
  localparam int OPW = N * OW;
  localparam int DPW = N * DW;

  typedef struct {
    int            g;
    logic [OW-1:0] opc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] res;
    int            t_iss;
    int            t_rsp;
  } txn_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [OPW-1:0] req_opcode = '0;
  logic [DPW-1:0] req_op1 = '0;
  logic [DPW-1:0] req_op2 = '0;
  logic [OW-1:0]  alu_opcode;
  logic [DW-1:0]  alu_op1, alu_op2;
  logic           alu_issue;
  logic [RW-1:0]  alu_res = '0;
  logic [N-1:0]   rsp_valid;
  logic [RW-1:0]  rsp_data;
  logic [N-1:0]   rsp_ready = '0;
  logic           busy;

  alu_arbiter #(.N_REQ(N), .DATA_W(DW), .OPC_W(OW), .RES_W(RW), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_issue(alu_issue), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rst_s = 1'b0;
  bit   rand_ops = 1'b1;
  bit   rand_ctl = 1'b0;

  txn_t iss_q[$];
  txn_t rsp_q[$];
  int   gr_log[$], gr_cyc[$], rs_log[$], rs_cyc[$];
  int   n_rsp = 0;
  logic [RW-1:0] last_rsp = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      3'd0:    alu_f = RW'(a) + RW'(b);
      3'd1:    alu_f = RW'(a) - RW'(b);
      3'd2:    alu_f = RW'(a & b);
      3'd3:    alu_f = RW'(a | b);
      3'd4:    alu_f = RW'(a ^ b);
      3'd5:    alu_f = {a, 1'b0};
      3'd6:    alu_f = RW'(~a);
      default: alu_f = (a < b) ? RW'(1) : RW'(0);
    endcase
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    onehot    = '0;
    onehot[g] = 1'b1;
  endfunction

  function automatic int which(input logic [N-1:0] v);
    which = -1;
    for (int i = 0; i < N; i++) if (v[i] && which < 0) which = i;
  endfunction

  // Behavioural ALU: the correct result appears only in the cycle LAT after issue.
  int            alu_t = -1000;
  logic [RW-1:0] alu_pend = '0;
  always @(negedge clk) begin
    if (alu_issue) begin
      alu_t    = cyc;
      alu_pend = alu_f(alu_opcode, alu_op1, alu_op2);
    end
    if (cyc == alu_t + LAT) alu_res = alu_pend;
    else                    alu_res = RW'($urandom);
  end

  // Reference model: one operation in flight, round-robin grant from m_ptr.
  bit            m_busy = 1'b0;
  int            m_ptr = 0, m_g = 0, m_tacc = 0, mg = -1;
  logic [N-1:0]  exp_ready;
  txn_t          t;
  always @(negedge clk) begin
    if (rst_s) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      iss_q.delete();
      rsp_q.delete();
      chk("rst_alu_issue", alu_issue, 0);
      chk("rst_alu_ops", {alu_opcode, alu_op1, alu_op2}, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
    end
    exp_ready = '0;
    mg = -1;
    if (!m_busy && !rst) begin
      for (int k = 0; k < N; k++)
        if (mg < 0 && req_valid[(m_ptr + k) % N]) mg = (m_ptr + k) % N;
      if (mg >= 0) exp_ready = onehot(mg);
    end
    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, m_busy);
    if (!rst) begin
      if (mg >= 0) begin
        t.g     = mg;
        t.opc   = req_opcode[mg*OW +: OW];
        t.a     = req_op1[mg*DW +: DW];
        t.b     = req_op2[mg*DW +: DW];
        t.res   = alu_f(t.opc, t.a, t.b);
        t.t_iss = cyc + 1;
        t.t_rsp = cyc + 2 + LAT;
        iss_q.push_back(t);
        rsp_q.push_back(t);
        m_busy = 1'b1;
        m_g    = mg;
        m_tacc = cyc;
      end else if (m_busy && cyc >= m_tacc + 2 + LAT && rsp_ready[m_g]) begin
        m_busy = 1'b0;
        m_ptr  = (m_g + 1) % N;
      end
    end
  end

  // Monitor: pops expectations when the DUT presents an issue or a response.
  txn_t e;
  always @(negedge clk) begin
    if (!rst && req_ready != '0) begin
      gr_log.push_back(which(req_ready));
      gr_cyc.push_back(cyc);
    end
    if (!rst_s) begin
      if (alu_issue) begin
        if (iss_q.size() == 0) begin
          chk("alu_issue_spurious", 1, 0);
        end else begin
          e = iss_q.pop_front();
          chk("alu_issue_cycle", cyc, e.t_iss);
          chk("alu_opcode", alu_opcode, e.opc);
          chk("alu_op1", alu_op1, e.a);
          chk("alu_op2", alu_op2, e.b);
        end
      end else if (iss_q.size() > 0 && cyc >= iss_q[0].t_iss) begin
        chk("alu_issue_missing", 0, 1);
        void'(iss_q.pop_front());
      end
      if (rsp_q.size() > 0 && cyc >= rsp_q[0].t_rsp) begin
        chk("rsp_valid", rsp_valid, onehot(rsp_q[0].g));
        chk("rsp_data", rsp_data, rsp_q[0].res);
        if (!rst && rsp_ready[rsp_q[0].g]) begin
          last_rsp = rsp_data;
          rs_log.push_back(rsp_q[0].g);
          rs_cyc.push_back(cyc);
          n_rsp++;
          void'(rsp_q.pop_front());
        end
      end else begin
        chk("rsp_valid_idle", rsp_valid, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ops) begin
      req_opcode = OPW'($urandom);
      req_op1    = DPW'($urandom);
      req_op2    = DPW'($urandom);
    end
    if (rand_ctl) begin
      req_valid = N'($urandom);
      rsp_ready = N'($urandom | $urandom);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    gr_log.delete(); gr_cyc.delete(); rs_log.delete(); rs_cyc.delete();
  endtask

  int base;
  initial begin
    // Reset with every requester valid, then a single directed add on req0.
    req_valid = '1;
    rsp_ready = '1;
    do_reset(2);
    clear_logs();
    base = n_rsp;
    req_valid = 3'b001;
    req_opcode[0 +: OW] = 3'b000;
    req_op1[0 +: DW]    = 4'h3;
    req_op2[0 +: DW]    = 4'h5;
    step();
    req_valid = '0;
    repeat (8) step();
    chk("single_grants", gr_log.size(), 1);
    if (gr_log.size() >= 1) chk("single_first_grant", gr_log[0], 0);
    chk("single_rsp_count", n_rsp - base, 1);
    chk("single_rsp_data", last_rsp, 5'h08);
    if (rs_cyc.size() >= 1 && gr_cyc.size() >= 1)
      chk("single_latency", rs_cyc[0] - gr_cyc[0], 2 + LAT);

    // Fairness: req0 and req1 continuously valid for eight operations.
    do_reset(1);
    clear_logs();
    req_valid = 3'b011;
    rsp_ready = '1;
    repeat (8 * (LAT + 3)) step();
    req_valid = '0;
    repeat (12) step();
    chk("fair_grants", gr_log.size(), 8);
    chk("fair_rsps", rs_log.size(), 8);
    for (int k = 0; k < 8 && k < gr_log.size() && k < rs_log.size(); k++) begin
      chk("fair_grant_order", gr_log[k], k % 2);
      chk("fair_rsp_order", rs_log[k], k % 2);
    end

    // Backpressure: req0 holds off its response for 5 RESP cycles while req1 waits.
    do_reset(1);
    clear_logs();
    req_valid = 3'b011;
    rsp_ready = 3'b110;
    repeat (2 + LAT + 5) step();
    rsp_ready = '1;
    repeat (2) step();
    req_valid = '0;
    repeat (10) step();
    chk("bp_grants", gr_log.size(), 2);
    if (gr_log.size() >= 2 && rs_cyc.size() >= 1) begin
      chk("bp_second_grant", gr_log[1], 1);
      chk("bp_grant_after_rsp", gr_cyc[1], rs_cyc[0] + 1);
      chk("bp_rsp_wait", rs_cyc[0] - gr_cyc[0], 2 + LAT + 5);
    end

    // Reset in the middle of WAIT: the operation must vanish.
    clear_logs();
    base = n_rsp;
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("midwait_grants", gr_log.size(), 1);
    chk("midwait_no_rsp", n_rsp - base, 0);

    // Wrap-around: req2 alone, then req0 and req2 together -> req0.
    do_reset(1);
    clear_logs();
    req_valid = 3'b100;
    step();
    req_valid = '0;
    repeat (8) step();
    req_valid = 3'b101;
    step();
    req_valid = '0;
    repeat (8) step();
    chk("wrap_grants", gr_log.size(), 2);
    if (gr_log.size() >= 2) begin
      chk("wrap_first", gr_log[0], 2);
      chk("wrap_second", gr_log[1], 0);
    end

    // Random traffic and response backpressure.
    rand_ctl = 1'b1;
    repeat (500) step();
    rand_ctl  = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (12) step();
    chk("drain_rsp_q", rsp_q.size(), 0);
    chk("drain_iss_q", iss_q.size(), 0);
    chk("drain_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
